fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the MIPS 5-stage pipeline. It owns the PC, requests words from the instruction cache, and presents (inst, pc, valid) to the decode stage, where the controller decodes it. A one-entry skid buffer absorbs decode stalls. It honours MIPS branch delay slots for decode-stage redirects and flushes immediately on exception redirects.

Parameters:
RESET_PC  32'h0000_0000  PC of first fetch after reset (word aligned)

Ports:
clk  input  1  main clock
rst  input  1  asynchronous reset, active-low (rst=0 resets)
id_ready  input  1  decode consumes id_* this cycle when id_valid=1 (pipeline ctrl_en)
id_redirect  input  1  taken jump/branch in decode; qualified by id_valid & id_ready
id_target  input  32  jump/branch target (word aligned)
exc_redirect  input  1  exception/ERET redirect; flush everything
exc_target  input  32  exception/ERET target
ic_req  output  1  instruction-cache request
ic_addr  output  32  fetch address, stable while ic_req=1
ic_ack  input  1  cache returns ic_data this cycle; ignored unless ic_req=1
ic_data  input  32  fetched word
id_valid  output  1  id_inst/id_pc hold a live instruction
id_inst  output  32  instruction to decoder (32'h0 = NOP when invalid)
id_pc  output  32  address of id_inst

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=S_IDLE, ic_req=0, id_valid=0, id_inst=0, id_pc=0, skid empty, redirect_pending=0.
- States: S_IDLE -> S_REQ unconditionally on first clock after reset release. S_REQ: normal fetch. S_DROP: in-flight request killed by exception.
- ic_req = (state!=S_IDLE) & ~skid_valid. ic_addr = pc in S_REQ, or the latched killed address in S_DROP. Once asserted, ic_req/ic_addr hold until ic_ack; never withdrawn mid-request. The only exception is skid becoming full, which can only happen on an ack cycle.
- Accepted ack in S_REQ: word goes to id regs if ~id_valid or id_ready; otherwise it goes to skid. pc <= redirect_pending ? pending_target : pc+4, then redirect_pending cleared. Throughput is 1 inst/cycle with a zero-wait cache.
- Decode consume (id_valid & id_ready) with no new word: id regs <= skid if skid_valid (skid cleared); otherwise id_valid <= 0 and id_inst <= 0.
- Ack, consume and skid valid in the same cycle: id regs <= skid, and the new word goes to skid.
- id_redirect (delay slot preserved; the delay-slot instruction is always delivered):
  - If ic_ack this cycle or skid_valid: pc <= id_target.
  - Otherwise: redirect_pending=1, pending_target=id_target.
- exc_redirect (priority over id_redirect and ack): id_valid <= 0, id_inst <= 0, skid cleared, redirect_pending cleared, pc <= exc_target.
  - If ic_req=1 and no ic_ack this cycle: state <= S_DROP.
  - In S_DROP, the old address is held until ack, the data is discarded, then state <= S_REQ.
  - A second exc_redirect in S_DROP only updates pc.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. Bits [1:0] are passed through unchecked.
- No combinational path from id_ready to ic_req.

Test Plan:
- Reset release, zero-wait cache returning addr as data -> ic_addr 0,4,8 on consecutive cycles; id_inst 0,4,8 with id_valid high from cycle 2.
- id_ready=0 for 3 cycles during streaming -> skid holds 0x8; ic_req low while skid full; no word lost or duplicated; sequence 0x4,0x8,0xC resumes.
- Branch at 0x10 with id_redirect (id_target=0x40) while fetch of 0x14 is still pending (cache 2-cycle latency) -> 0x14 delivered, then 0x40, 0x44.
- exc_redirect (exc_target=0x180) while 0x20 is in flight and the cache acks 2 cycles later -> ic_addr holds 0x20 until ack; data dropped; next request is 0x180; id_valid=0 meanwhile.
- exc_redirect and id_redirect in the same cycle -> next fetch 0x180, pending redirect cleared.
- Assert rst low mid-request -> all outputs return to reset values immediately; first fetch after release is RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the I-cache request and feeds
// decode through a one-entry skid buffer, honouring branch delay slots.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ready,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ack,
    input  logic [31:0] ic_data,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        redirect_pending;
    logic [31:0] pending_target;

    logic        ack_ok;
    logic        word_ok;
    logic        consume;
    logic        br_take;
    logic        skid_load;
    logic        drop_start;

    // ic_req is built from registers only, so id_ready never reaches it combinationally
    assign ic_req     = (state != S_IDLE) && !skid_valid;
    assign ic_addr    = (state == S_DROP) ? drop_addr : pc;

    assign ack_ok     = ic_req && ic_ack;
    assign word_ok    = ack_ok && (state == S_REQ);
    assign consume    = id_valid && id_ready;
    assign br_take    = consume && id_redirect;
    assign skid_load  = word_ok && id_valid && (!id_ready || skid_valid);
    assign drop_start = (state == S_REQ) && exc_redirect && ic_req && !ic_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (drop_start) state_nxt = S_DROP;
            S_DROP:  if (ack_ok) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc               <= RESET_PC;
            id_valid         <= 1'b0;
            id_inst          <= 32'h0;
            id_pc            <= 32'h0;
            skid_valid       <= 1'b0;
            redirect_pending <= 1'b0;
        end else if (exc_redirect) begin
            pc               <= exc_target;
            id_valid         <= 1'b0;
            id_inst          <= 32'h0;
            skid_valid       <= 1'b0;
            redirect_pending <= 1'b0;
        end else begin
            if (word_ok) begin
                if (!id_valid || consume) begin
                    id_valid <= 1'b1;
                    id_inst  <= skid_valid ? skid_inst : ic_data;
                    id_pc    <= skid_valid ? skid_pc : pc;
                end else begin
                    skid_valid <= 1'b1;
                end
                pc               <= redirect_pending ? pending_target : pc + 32'd4;
                redirect_pending <= 1'b0;
            end else if (consume) begin
                if (skid_valid) begin
                    id_inst    <= skid_inst;
                    id_pc      <= skid_pc;
                    skid_valid <= 1'b0;
                end else begin
                    id_valid <= 1'b0;
                    id_inst  <= 32'h0;
                end
            end
            // Delay slot already captured (acked now or in skid): jump straight away
            if (br_take) begin
                if (word_ok || skid_valid) begin
                    pc <= id_target;
                end else begin
                    redirect_pending <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_inst <= ic_data;
            skid_pc   <= pc;
        end
        if (br_take && !word_ok && !skid_valid) begin
            pending_target <= id_target;
        end
        if (drop_start) begin
            drop_addr <= pc;
        end
    end

endmodule
